// File: rtl/fsm_rx_sync_pkg.sv
// Shared types and constants for the fsm_rx_sync frame synchroniser.
package fsm_rx_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam logic [2:0] SYNC_PATTERN = 3'b110;
  localparam int         SYNC_PERIOD  = 3;
  localparam logic [1:0] PH_LAST      = 2'(SYNC_PERIOD - 1);

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    return (ph == PH_LAST) ? 2'd0 : ph + 2'd1;
  endfunction

endpackage

// File: rtl/fsm_rx_sync_sat_counter.sv
// Parameterised-width saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fsm_rx_sync.sv
// Receive-side frame synchroniser for the period-3 "110" marker stream.
// Define FSM_RX_SYNC_ERRCNT_EN to build the bad-frame error counter; otherwise err_cnt is tied to 0.
module fsm_rx_sync
  import fsm_rx_sync_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inp,
  input  logic             err_clr,
  output logic             lock,
  output logic             frame_strb,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  state_e     state_q;
  logic [2:0] w_q;
  logic [1:0] ph_q;
  logic [3:0] good_q;
  logic [3:0] bad_q;
  logic       lock_q;
  logic       strb_q;

  logic       match;
  logic       eval;
  logic [1:0] ph_d;
  logic [3:0] good_d;
  logic [3:0] bad_d;
  logic       err_inc;

  // Match is judged on the window before this edge's shift.
  always_comb begin
    match   = (w_q == SYNC_PATTERN);
    eval    = (ph_q == PH_LAST);
    ph_d    = next_phase(ph_q);
    good_d  = good_q + 4'd1;
    bad_d   = bad_q + 4'd1;
    err_inc = (state_q == LOCKED) && eval && !match;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      w_q     <= 3'b000;
      ph_q    <= 2'd0;
      good_q  <= 4'd0;
      bad_q   <= 4'd0;
      lock_q  <= 1'b0;
      strb_q  <= 1'b0;
    end else begin
      w_q    <= {w_q[1:0], inp};
      strb_q <= 1'b0;
      case (state_q)
        HUNT: begin
          ph_q   <= 2'd0;
          lock_q <= 1'b0;
          if (match) begin
            state_q <= CHECK;
            good_q  <= 4'd1;
          end
        end

        CHECK: begin
          ph_q <= ph_d;
          if (eval) begin
            if (match) begin
              good_q <= good_d;
              if (good_d == LOCK_C) begin
                state_q <= LOCKED;
                bad_q   <= 4'd0;
                lock_q  <= 1'b1;
                strb_q  <= 1'b1;
              end
            end else begin
              state_q <= HUNT;
              good_q  <= 4'd0;
              ph_q    <= 2'd0;
            end
          end
        end

        LOCKED: begin
          ph_q <= ph_d;
          if (eval) begin
            if (match) begin
              bad_q  <= 4'd0;
              strb_q <= 1'b1;
            end else begin
              bad_q <= bad_d;
              if (bad_d == UNLOCK_C) begin
                state_q <= HUNT;
                ph_q    <= 2'd0;
                lock_q  <= 1'b0;
              end
            end
          end
        end

        default: begin
          state_q <= HUNT;
          ph_q    <= 2'd0;
          good_q  <= 4'd0;
          bad_q   <= 4'd0;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lock       = lock_q;
  assign frame_strb = strb_q;

`ifdef FSM_RX_SYNC_ERRCNT_EN
  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr_i(err_clr),
    .inc_i(err_inc),
    .cnt_o(err_cnt)
  );
`else
  logic unused_err;
  assign unused_err = err_clr ^ err_inc;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_fsm_rx_sync.sv
// Directed bench for fsm_rx_sync: frame table plus reset, async-reset and phase-shift sequences.
module tb_fsm_rx_sync;

  localparam logic [2:0] G = 3'b110;
  localparam logic [2:0] B = 3'b111;
  localparam int NFR = 27;

  typedef struct {
    logic [2:0] bits;
    logic       clr;
    logic       lock;
    logic       strb;
    logic [1:0] err;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       inp;
  logic       err_clr;
  logic       lock;
  logic       frame_strb;
  logic [1:0] err_cnt;

  int ncmp;
  int nerr;
  vec_t tbl [NFR];

  fsm_rx_sync #(
    .LOCK_CNT  (4),
    .UNLOCK_CNT(2),
    .ERR_W     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .inp       (inp),
    .err_clr   (err_clr),
    .lock      (lock),
    .frame_strb(frame_strb),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int eerr(input int e);
`ifdef FSM_RX_SYNC_ERRCNT_EN
    return e;
`else
    return (e == 0) ? 0 : 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic b, input logic c);
    inp     = b;
    err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int el, input int es, input int ee);
    chk({tag, " lock"}, int'(lock), el);
    chk({tag, " strb"}, int'(frame_strb), es);
    chk({tag, " err"},  int'(err_cnt), ee);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    ncmp = 0;
    nerr = 0;
    // Each row is one 3-bit frame; expectations are the outputs right after the
    // frame's first edge, which is where the previous frame gets evaluated.
    tbl = '{
      '{G, 1'b0, 1'b0, 1'b0, 2'd0},  // F1
      '{G, 1'b0, 1'b0, 1'b0, 2'd0},  // F2  hunt match of F1
      '{G, 1'b0, 1'b0, 1'b0, 2'd0},
      '{G, 1'b0, 1'b0, 1'b0, 2'd0},
      '{G, 1'b0, 1'b1, 1'b1, 2'd0},  // F5  lock after edge 13
      '{G, 1'b0, 1'b1, 1'b1, 2'd0},
      '{B, 1'b0, 1'b1, 1'b1, 2'd0},  // F7  single corrupt frame
      '{G, 1'b0, 1'b1, 1'b0, 2'd1},
      '{G, 1'b0, 1'b1, 1'b1, 2'd1},  // strobe resumes
      '{B, 1'b0, 1'b1, 1'b1, 2'd1},  // F10 two corrupt frames
      '{B, 1'b0, 1'b1, 1'b0, 2'd2},
      '{G, 1'b0, 1'b0, 1'b0, 2'd3},  // F12 unlock
      '{G, 1'b0, 1'b0, 1'b0, 2'd3},  // hunt match of F12
      '{G, 1'b0, 1'b0, 1'b0, 2'd3},
      '{G, 1'b0, 1'b0, 1'b0, 2'd3},
      '{G, 1'b0, 1'b1, 1'b1, 2'd3},  // F16 relock, 9 edges after match
      '{B, 1'b0, 1'b1, 1'b1, 2'd3},
      '{B, 1'b0, 1'b1, 1'b0, 2'd3},  // F18 saturated at 3
      '{G, 1'b1, 1'b0, 1'b0, 2'd0},  // F19 clear beats increment on unlock edge
      '{G, 1'b0, 1'b0, 1'b0, 2'd0},  // hunt match of F19
      '{B, 1'b0, 1'b0, 1'b0, 2'd0},  // F21 third frame bad in CHECK
      '{G, 1'b0, 1'b0, 1'b0, 2'd0},
      '{G, 1'b0, 1'b0, 1'b0, 2'd0},
      '{G, 1'b0, 1'b0, 1'b0, 2'd0},
      '{G, 1'b0, 1'b0, 1'b0, 2'd0},
      '{G, 1'b0, 1'b1, 1'b1, 2'd0},  // F26 relock
      '{G, 1'b0, 1'b1, 1'b1, 2'd0}
    };

    reset   = 1'b1;
    inp     = 1'b0;
    err_clr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0);
    reset = 1'b0;

    for (int k = 0; k < NFR; k++) begin
      for (int j = 0; j < 3; j++) begin
        step(tbl[k].bits[2-j], (j == 0) ? tbl[k].clr : 1'b0);
        chk_all($sformatf("F%0d.e%0d", k + 1, j), int'(tbl[k].lock),
                (j == 0) ? int'(tbl[k].strb) : 0, eerr(int'(tbl[k].err)));
      end
    end

    // One bad frame then a good one so err_cnt is non-zero when reset hits.
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk_all("prebad", 1, 0, eerr(1));
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_all("pregood", 1, 1, eerr(1));
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0);

    @(posedge clk);
    #1;
    reset = 1'b0;

    // Stream starts phase-shifted: 0,1,1,0,1,1,...
    for (int n = 1; n <= 17; n++) begin
      step(((n - 1) % 3) != 0, 1'b0);
      chk_all($sformatf("shift.e%0d", n), (n >= 14) ? 1 : 0,
              (n == 14 || n == 17) ? 1 : 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
